// File: rtl/dvi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dvi_frame_scheduler
// Purpose  : Raster timing generator for the DVI transmit path. Produces
//            den/hsync/vsync and arbitrates frame ownership between the test
//            pattern generator (source 0) and the framebuffer reader
//            (source 1). Ownership only changes at frame boundaries.
// Clocking : single domain, pixel_clock rising edge; synchronous active-low
//            reset (resetn).
// Revision : 1.0 - initial release
// ============================================================================
module dvi_frame_scheduler #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        pixel_clock,
    input  logic        resetn,
    input  logic        run,
    input  logic        src1_req,
    output logic        src_rd,
    output logic        src_frame_start,
    output logic        src_sel,
    input  logic [23:0] src0_data,
    input  logic [23:0] src1_data,
    output logic        video_den,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic [23:0] video_pixel,
    output logic        frame_done
);

    // ------------------------------------------------------------------------
    // Raster geometry, all pre-sized to the 12-bit counter width
    // ------------------------------------------------------------------------
    localparam logic [11:0] c_H_TOTAL    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_V_TOTAL    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] c_H_LAST     = c_H_TOTAL - 12'd1;
    localparam logic [11:0] c_V_LAST     = c_V_TOTAL - 12'd1;
    localparam logic [11:0] c_H_ACTIVE   = 12'(H_ACTIVE);
    localparam logic [11:0] c_V_ACTIVE   = 12'(V_ACTIVE);
    localparam logic [11:0] c_HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_VS_START   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
    // Level driven on the sync outputs when no pulse is present
    localparam logic        c_SYNC_IDLE  = ~SYNC_POL;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Counter stage
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [11:0] w_h_next;
    logic [11:0] w_v_next;

    logic        w_go;         // raster advances this cycle
    logic        w_load_sel;   // ownership is re-sampled this cycle
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_end;  // last raster position while running
    logic        w_origin;     // raster (0,0) while running
    logic        w_active;
    logic        w_hs;
    logic        w_vs;

    // ------------------------------------------------------------------------
    // Stage 1 (N+1): read strobe and pulses toward the owner
    // ------------------------------------------------------------------------
    logic        r_src_rd;
    logic        r_frame_start;
    logic        r_frame_done;
    logic        r_src_sel;
    logic        r_hs;
    logic        r_vs;

    // ------------------------------------------------------------------------
    // Stage 2 (N+2): video outputs toward dvi_tx_top
    // ------------------------------------------------------------------------
    logic        r_video_den;
    logic        r_video_hsync;
    logic        r_video_vsync;
    logic [23:0] r_video_pixel;
    logic [23:0] w_pixel_mux;

    // Raster position decode of the current counter values
    always_comb begin
        w_h_last    = (r_h_cnt == c_H_LAST);
        w_v_last    = (r_v_cnt == c_V_LAST);
        w_frame_end = (r_state == S_ACTIVE) && w_h_last && w_v_last;
        w_origin    = w_go && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
        w_active    = w_go && (r_h_cnt < c_H_ACTIVE) && (r_v_cnt < c_V_ACTIVE);
        w_hs        = w_go && (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
        w_vs        = w_go && (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    end

    // Next-state logic; the first cycle with run high already counts at (0,0)
    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_load_sel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_ACTIVE;
                    w_go         = 1'b1;
                    w_load_sel   = 1'b1;
                end
            end
            S_ACTIVE: begin
                w_go = 1'b1;
                if (r_h_cnt == c_H_LAST && r_v_cnt == c_V_LAST) begin
                    w_load_sel = 1'b1;
                    if (!run) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Horizontal/vertical counter advance with wrap at the raster totals
    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_go) begin
            if (w_h_last) begin
                w_h_next = 12'd0;
                w_v_next = w_v_last ? 12'd0 : (r_v_cnt + 12'd1);
            end else begin
                w_h_next = r_h_cnt + 12'd1;
            end
        end
    end

    // State and raster counter registers
    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else begin
            r_state <= w_state_next;
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    // Stage 1: source strobes, frame pulses, ownership and delayed syncs
    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            r_src_rd      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_src_sel     <= 1'b0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
        end else begin
            r_src_rd      <= w_active;
            r_frame_start <= w_origin;
            r_frame_done  <= w_frame_end;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            if (w_load_sel) begin
                r_src_sel <= src1_req;
            end
        end
    end

    // Owner's data is present in the same cycle as the stage-1 read strobe;
    // the owner register changes only at a boundary, so it is stable here
    always_comb begin
        w_pixel_mux = r_src_sel ? src1_data : src0_data;
    end

    // Stage 2: video outputs; pixel forced to zero outside active video
    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            r_video_den   <= 1'b0;
            r_video_hsync <= c_SYNC_IDLE;
            r_video_vsync <= c_SYNC_IDLE;
            r_video_pixel <= 24'd0;
        end else begin
            r_video_den   <= r_src_rd;
            r_video_hsync <= r_hs ^ c_SYNC_IDLE;
            r_video_vsync <= r_vs ^ c_SYNC_IDLE;
            r_video_pixel <= r_src_rd ? w_pixel_mux : 24'd0;
        end
    end

    assign src_rd          = r_src_rd;
    assign src_frame_start = r_frame_start;
    assign src_sel         = r_src_sel;
    assign frame_done      = r_frame_done;
    assign video_den       = r_video_den;
    assign video_hsync     = r_video_hsync;
    assign video_vsync     = r_video_vsync;
    assign video_pixel     = r_video_pixel;

endmodule
`default_nettype wire

// File: tb/tb_dvi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvi_frame_scheduler
// Purpose  : Self-checking bench for dvi_frame_scheduler using a small raster
//            (H 4/1/1/1, V 2/1/1/1) and a position-based reference model
//            feeding an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvi_frame_scheduler;

    localparam int HA  = 4;
    localparam int HFP = 1;
    localparam int HS  = 1;
    localparam int HBP = 1;
    localparam int VA  = 2;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;   // 7
    localparam int VT  = VA + VFP + VS + VBP;   // 5
    localparam int FT  = HT * VT;               // 35
    localparam logic [23:0] SRC1_PIX = 24'hABCDEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic        src1_req = 1'b0;
    logic        clr_rd = 1'b0;
    logic [23:0] src0_data;
    logic [23:0] src1_data;
    logic        src_rd;
    logic        src_frame_start;
    logic        src_sel;
    logic        video_den;
    logic        video_hsync;
    logic        video_vsync;
    logic [23:0] video_pixel;
    logic        frame_done;
    logic [30:0] obs;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;

    // reference model state
    bit          m_running = 1'b0;
    int          m_pos = 0;
    bit          m_owner = 1'b0;
    int          m_rd_idx = 0;
    bit          p_den = 1'b0;
    bit          p_hs = 1'b0;
    bit          p_vs = 1'b0;
    logic [23:0] p_pix = 24'd0;
    logic [30:0] sb_q[$];
    logic [30:0] sb_exp;

    always #5 clk = ~clk;

    dvi_frame_scheduler #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .SYNC_POL (1'b1)
    ) dut (
        .pixel_clock     (clk),
        .resetn          (resetn),
        .run             (run),
        .src1_req        (src1_req),
        .src_rd          (src_rd),
        .src_frame_start (src_frame_start),
        .src_sel         (src_sel),
        .src0_data       (src0_data),
        .src1_data       (src1_data),
        .video_den       (video_den),
        .video_hsync     (video_hsync),
        .video_vsync     (video_vsync),
        .video_pixel     (video_pixel),
        .frame_done      (frame_done)
    );

    // Source 0 presents the number of reads it has served so far
    always @(posedge clk) begin
        if (clr_rd) rd_count <= 0;
        else if (src_rd === 1'b1) rd_count <= rd_count + 1;
    end
    assign src0_data = 24'(rd_count);
    assign src1_data = SRC1_PIX;

    assign obs = {src_rd, src_frame_start, src_sel, frame_done,
                  video_den, video_hsync, video_vsync, video_pixel};

    // Predict the outputs of the next cycle from the inputs of this cycle
    function automatic void model_step();
        int h;
        int v;
        bit go;
        bit rd;
        bit fs;
        bit fd;
        bit hs;
        bit vs;
        logic [23:0] pix;
        logic [30:0] e;
        if (clr_rd) m_rd_idx = 0;
        if (!resetn) begin
            m_running = 1'b0;
            m_pos = 0;
            m_owner = 1'b0;
            p_den = 1'b0;
            p_hs = 1'b0;
            p_vs = 1'b0;
            p_pix = 24'd0;
            e = 31'd0;
        end else begin
            go = m_running || run;
            if (!m_running && run) m_owner = src1_req;
            h = m_pos % HT;
            v = m_pos / HT;
            rd = go && (h < HA) && (v < VA);
            fs = go && (m_pos == 0);
            fd = m_running && (m_pos == FT - 1);
            hs = go && (h >= HA + HFP) && (h < HA + HFP + HS);
            vs = go && (v >= VA + VFP) && (v < VA + VFP + VS);
            if (fd) m_owner = src1_req;
            pix = rd ? (m_owner ? SRC1_PIX : 24'(m_rd_idx)) : 24'd0;
            if (rd) m_rd_idx++;
            e = {rd, fs, m_owner, fd, p_den, p_hs, p_vs, p_pix};
            p_den = rd;
            p_hs = hs;
            p_vs = vs;
            p_pix = pix;
            m_running = m_running ? !((m_pos == FT - 1) && !run) : run;
            if (go) m_pos = (m_pos + 1) % FT;
        end
        sb_q.push_back(e);
    endfunction

    // Apply this cycle's inputs, advance one clock, fetch the expectation
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        sb_exp = sb_q.pop_front();
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        run = 1'b0;
        src1_req = 1'b0;
        clr_rd = 1'b1;
        repeat (2) cycle();
        resetn = 1'b1;
        clr_rd = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        run = 1'b1;
        src1_req = 1'b1;
        clr_rd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++;
            if (obs !== 31'd0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got=%h want=0", k, obs);
            end
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL reset_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
        end
        clr_rd = 1'b0;
    endtask

    task automatic test_raster();
        int den_cnt = 0;
        int vs_cnt = 0;
        apply_reset();
        run = 1'b1;
        for (int k = 1; k <= FT; k++) begin
            cycle();
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL raster_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
            if (video_den === 1'b1) den_cnt++;
            if (video_vsync === 1'b1) vs_cnt++;
            if (k == 1) begin
                checks++;
                if (src_frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL raster_frame_start k=1 got=%b want=1", src_frame_start);
                end
            end
            if (k == 7) begin
                checks++;
                if (video_hsync !== 1'b1) begin
                    errors++;
                    $display("FAIL raster_hsync k=7 got=%b want=1", video_hsync);
                end
            end
            if (k == 23) begin
                checks++;
                if (video_vsync !== 1'b1) begin
                    errors++;
                    $display("FAIL raster_vsync k=23 got=%b want=1", video_vsync);
                end
            end
            if (k == 12) begin
                checks++;
                if (video_pixel !== 24'h000007 || video_den !== 1'b1) begin
                    errors++;
                    $display("FAIL raster_last_pixel k=12 got=%h/%b want=000007/1", video_pixel, video_den);
                end
            end
            if (k == FT) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL raster_frame_done k=35 got=%b want=1", frame_done);
                end
            end
        end
        checks++;
        if (den_cnt != 8 || vs_cnt != 7) begin
            errors++;
            $display("FAIL raster_counts den=%0d vsync=%0d want 8 and 7", den_cnt, vs_cnt);
        end
    endtask

    task automatic test_handover();
        apply_reset();
        run = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k - 1 == 10) src1_req = 1'b1;
            cycle();
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL handover_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
            if (k == 34 || k == 35) begin
                checks++;
                if (src_sel !== (k == 35)) begin
                    errors++;
                    $display("FAIL handover_sel k=%0d got=%b want=%b", k, src_sel, k == 35);
                end
            end
            if (k == 37) begin
                checks++;
                if (video_pixel !== SRC1_PIX || video_den !== 1'b1) begin
                    errors++;
                    $display("FAIL handover_pixel k=37 got=%h want=%h", video_pixel, SRC1_PIX);
                end
            end
        end
    endtask

    task automatic test_req_pulse();
        apply_reset();
        run = 1'b1;
        for (int k = 1; k <= 2 * FT + 2; k++) begin
            if (k - 1 == 10) src1_req = 1'b1;
            if (k - 1 == 21) src1_req = 1'b0;
            cycle();
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL pulse_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
            if (src_sel !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL pulse_sel k=%0d got=%b want=0", k, src_sel);
            end
        end
    endtask

    task automatic test_run_drop();
        apply_reset();
        run = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            if (k - 1 == 15) run = 1'b0;
            if (k - 1 == 40) run = 1'b1;
            cycle();
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL rundrop_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
            if (k == FT) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL rundrop_frame_done k=35 got=%b want=1", frame_done);
                end
            end
            if (k >= 36 && k <= 40) begin
                checks++;
                if (obs !== 31'd0) begin
                    errors++;
                    $display("FAIL rundrop_idle k=%0d got=%h want=0", k, obs);
                end
            end
            if (k == 41) begin
                checks++;
                if (src_frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL rundrop_restart k=41 got=%b want=1", src_frame_start);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        run = 1'b1;
        src1_req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k - 1 == 20) resetn = 1'b0;
            if (k - 1 == 21) resetn = 1'b1;
            cycle();
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL midreset_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
            if (k == 20) begin
                checks++;
                if (src_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_sel_before k=20 got=%b want=1", src_sel);
                end
            end
            if (k == 21) begin
                checks++;
                if (obs !== 31'd0) begin
                    errors++;
                    $display("FAIL midreset_flush k=21 got=%h want=0", obs);
                end
            end
            if (k == 22) begin
                checks++;
                if (src_frame_start !== 1'b1 || video_den !== 1'b0 || video_pixel !== 24'd0) begin
                    errors++;
                    $display("FAIL midreset_restart k=22 got fs=%b den=%b pix=%h want 1/0/0",
                             src_frame_start, video_den, video_pixel);
                end
            end
            if (k == 23) begin
                checks++;
                if (video_den !== 1'b1 || video_pixel !== SRC1_PIX) begin
                    errors++;
                    $display("FAIL midreset_first_den k=23 got den=%b pix=%h want 1/%h",
                             video_den, video_pixel, SRC1_PIX);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int fd_cnt = 0;
        apply_reset();
        run = 1'b1;
        for (int k = 1; k <= 3 * FT; k++) begin
            src1_req = 1'($urandom_range(0, 1));
            cycle();
            checks++;
            if (obs !== sb_exp) begin
                errors++;
                $display("FAIL b2b_sb k=%0d got=%h want=%h", k, obs, sb_exp);
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        checks++;
        if (fd_cnt != 3) begin
            errors++;
            $display("FAIL b2b_frames got=%0d want=3", fd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_handover();
        test_req_pulse();
        test_run_drop();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
